// File: rtl/reg_sink_pkg.sv
// Shared constants and helpers for the destination register sink.
// NULL_INDEX is the single definition also used by the destination muxer.
package reg_sink_pkg;

  localparam int              NUM_REGS   = 16;
  localparam int              REG_W      = 32;
  localparam logic [32-1:0]   NULL_INDEX = 32'h0000_0010;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_STAGE = 2'd1,
    WR_DROP  = 2'd2
  } wr_kind_e;

  // An index names a real register only if it is in range and is not the null destination
  function automatic logic is_writable(input logic [REG_W-1:0] index,
                                       input logic [REG_W-1:0] num_regs,
                                       input logic [REG_W-1:0] null_index);
    return (index != null_index) && (index < num_regs);
  endfunction

endpackage

// File: rtl/reg_sink_stage.sv
// One-entry staging register between the execute result and the register array.
// Produces the accept/ready handshake, the commit strobe and the discard strobe.
module reg_sink_stage
  import reg_sink_pkg::*;
#(
  parameter int unsigned        UUID     = 32'd0,
  parameter int                 NREGS    = 16,
  parameter logic [REG_W-1:0]   NULL_IDX = 32'h0000_0010,
  parameter int                 IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [REG_W-1:0] wr_index,
  input  logic [REG_W-1:0] wr_data,
  input  logic             stall,
  output logic             wr_ready,
  output logic             commit,
  output logic             discard,
  output logic             stage_valid,
  output logic [IDX_W-1:0] stage_index,
  output logic [REG_W-1:0] stage_data
);

  wr_kind_e          wr_kind_s;
  logic              stage_valid_r;
  logic [IDX_W-1:0]  stage_index_r;
  logic [REG_W-1:0]  stage_data_r;
  logic              unused_uuid_s;

  assign unused_uuid_s = ^UUID;

  // A full stage that is stalled cannot take another write
  assign wr_ready = !(stage_valid_r && stall);
  assign commit   = stage_valid_r && !stall;
  assign discard  = (wr_kind_s == WR_DROP);

  // Classify the write accepted this cycle
  always_comb begin
    wr_kind_s = WR_IDLE;
    if (wr_valid && wr_ready) begin
      if (is_writable(wr_index, REG_W'(NREGS), NULL_IDX)) begin
        wr_kind_s = WR_STAGE;
      end else begin
        wr_kind_s = WR_DROP;
      end
    end else begin
      wr_kind_s = WR_IDLE;
    end
  end

  // Staging register: a new write refills the stage in the same edge it commits
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_r <= 1'b0;
      stage_index_r <= '0;
      stage_data_r  <= '0;
    end else begin
      case (wr_kind_s)
        WR_STAGE: begin
          stage_valid_r <= 1'b1;
          stage_index_r <= wr_index[IDX_W-1:0];
          stage_data_r  <= wr_data;
        end
        default: begin
          if (commit) begin
            stage_valid_r <= 1'b0;
          end
        end
      endcase
    end
  end

  assign stage_valid = stage_valid_r;
  assign stage_index = stage_index_r;
  assign stage_data  = stage_data_r;

endmodule

// File: rtl/reg_sink.sv
// Destination-side register sink: staged commit into a 16-entry register file,
// two combinational read ports with stage bypass, commit and discard counters.
module reg_sink #(
  parameter int unsigned  UUID       = 32'd0,
  parameter string        NAME       = "",
  parameter int           NUM_REGS   = reg_sink_pkg::NUM_REGS,
  parameter logic [31:0]  NULL_INDEX = reg_sink_pkg::NULL_INDEX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Wr_valid,
  output logic        Wr_ready,
  input  logic [31:0] Wr_index,
  input  logic [31:0] Wr_data,
  input  logic        Stall,
  input  logic [31:0] Rd_a_index,
  input  logic [31:0] Rd_b_index,
  output logic [31:0] Rd_a,
  output logic [31:0] Rd_b,
  output logic [31:0] Commit_count,
  output logic [31:0] Discard_count
);
  import reg_sink_pkg::*;

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [REG_W-1:0]  regs_r [NUM_REGS];
  logic [31:0]       commit_count_r;
  logic [31:0]       discard_count_r;
  logic              commit_s;
  logic              discard_s;
  logic              stage_valid_s;
  logic [IDX_W-1:0]  stage_index_s;
  logic [REG_W-1:0]  stage_data_s;
  logic              unused_name_s;

  assign unused_name_s = (NAME == "");

  reg_sink_stage #(
    .UUID     (UUID ^ 32'h5354_4745),
    .NREGS    (NUM_REGS),
    .NULL_IDX (NULL_INDEX),
    .IDX_W    (IDX_W)
  ) u_stage (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (Wr_valid),
    .wr_index    (Wr_index),
    .wr_data     (Wr_data),
    .stall       (Stall),
    .wr_ready    (Wr_ready),
    .commit      (commit_s),
    .discard     (discard_s),
    .stage_valid (stage_valid_s),
    .stage_index (stage_index_s),
    .stage_data  (stage_data_s)
  );

  // Register array, written only by the stage commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (commit_s) begin
      regs_r[stage_index_s] <= stage_data_s;
    end
  end

  // Commit and discard counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_count_r  <= 32'd0;
      discard_count_r <= 32'd0;
    end else begin
      if (commit_s) begin
        commit_count_r <= commit_count_r + 32'd1;
      end
      if (discard_s) begin
        discard_count_r <= discard_count_r + 32'd1;
      end
    end
  end

  assign Commit_count  = commit_count_r;
  assign Discard_count = discard_count_r;

  // Read port A: out-of-range reads return zero, a staged write wins over the array
  always_comb begin
    Rd_a = '0;
    if (!is_writable(Rd_a_index, REG_W'(NUM_REGS), NULL_INDEX)) begin
      Rd_a = '0;
    end else if (stage_valid_s && (stage_index_s == Rd_a_index[IDX_W-1:0])) begin
      Rd_a = stage_data_s;
    end else begin
      Rd_a = regs_r[Rd_a_index[IDX_W-1:0]];
    end
  end

  // Read port B: same rules as port A, fully independent
  always_comb begin
    Rd_b = '0;
    if (!is_writable(Rd_b_index, REG_W'(NUM_REGS), NULL_INDEX)) begin
      Rd_b = '0;
    end else if (stage_valid_s && (stage_index_s == Rd_b_index[IDX_W-1:0])) begin
      Rd_b = stage_data_s;
    end else begin
      Rd_b = regs_r[Rd_b_index[IDX_W-1:0]];
    end
  end

endmodule

// File: tb/tb_reg_sink.sv
// Directed self-checking bench for reg_sink: reset, staging/bypass, discard,
// back-to-back commits, stall behaviour and reset of a pending write.
module tb_reg_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Wr_valid = 1'b0;
  logic        Wr_ready;
  logic [31:0] Wr_index = 32'd0;
  logic [31:0] Wr_data = 32'd0;
  logic        Stall = 1'b0;
  logic [31:0] Rd_a_index = 32'd0;
  logic [31:0] Rd_b_index = 32'd0;
  logic [31:0] Rd_a;
  logic [31:0] Rd_b;
  logic [31:0] Commit_count;
  logic [31:0] Discard_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_sink dut (
    .clk           (clk),
    .rst           (rst),
    .Wr_valid      (Wr_valid),
    .Wr_ready      (Wr_ready),
    .Wr_index      (Wr_index),
    .Wr_data       (Wr_data),
    .Stall         (Stall),
    .Rd_a_index    (Rd_a_index),
    .Rd_b_index    (Rd_b_index),
    .Rd_a          (Rd_a),
    .Rd_b          (Rd_b),
    .Commit_count  (Commit_count),
    .Discard_count (Discard_count)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Wr_valid = 1'b0;
    Wr_index = 32'd0;
    Wr_data  = 32'd0;
    Stall    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      Rd_a_index = i;
      Rd_b_index = 16 - i;
      #1;
      checks++;
      if (Rd_a !== 32'd0) begin
        errors++;
        $display("FAIL reset_rd_a[%0d]: got %h expected 00000000", i, Rd_a);
      end
      checks++;
      if (Rd_b !== 32'd0) begin
        errors++;
        $display("FAIL reset_rd_b[%0d]: got %h expected 00000000", 16 - i, Rd_b);
      end
    end
    checks++;
    if (Wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wr_ready: got %b expected 1", Wr_ready);
    end
    checks++;
    if (Commit_count !== 32'd0 || Discard_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", Commit_count, Discard_count);
    end
  endtask

  task automatic test_basic_write();
    do_reset();
    Wr_valid = 1'b1; Wr_index = 32'd3; Wr_data = 32'hDEAD_BEEF;
    Rd_a_index = 32'd3; Rd_b_index = 32'd3;
    cycle();
    idle();
    #1;
    checks++;
    if (Rd_a !== 32'hDEAD_BEEF || Rd_b !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_bypass: got %h/%h expected deadbeef/deadbeef", Rd_a, Rd_b);
    end
    checks++;
    if (Commit_count !== 32'd0) begin
      errors++;
      $display("FAIL basic_commit_early: got %0d expected 0", Commit_count);
    end
    cycle();
    cycle();
    Rd_b_index = 32'd4;
    #1;
    checks++;
    if (Rd_a !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_array: got %h expected deadbeef", Rd_a);
    end
    checks++;
    if (Rd_b !== 32'd0) begin
      errors++;
      $display("FAIL basic_other_reg: got %h expected 00000000", Rd_b);
    end
    checks++;
    if (Commit_count !== 32'd1) begin
      errors++;
      $display("FAIL basic_commit_count: got %0d expected 1", Commit_count);
    end
  endtask

  task automatic test_discard();
    do_reset();
    Wr_valid = 1'b1; Wr_index = 32'h10; Wr_data = 32'h1234_5678;
    cycle();
    checks++;
    if (Discard_count !== 32'd1) begin
      errors++;
      $display("FAIL discard_first: got %0d expected 1", Discard_count);
    end
    Wr_index = 32'h40; Wr_data = 32'd1;
    cycle();
    idle();
    cycle();
    Rd_a_index = 32'd0; Rd_b_index = 32'h10;
    #1;
    checks++;
    if (Discard_count !== 32'd2 || Commit_count !== 32'd0) begin
      errors++;
      $display("FAIL discard_counts: got %0d/%0d expected 2/0", Discard_count, Commit_count);
    end
    checks++;
    if (Rd_a !== 32'd0 || Rd_b !== 32'd0) begin
      errors++;
      $display("FAIL discard_regs: got %h/%h expected 00000000/00000000", Rd_a, Rd_b);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    Rd_a_index = 32'd5; Rd_b_index = 32'd6;
    Wr_valid = 1'b1; Wr_index = 32'd5; Wr_data = 32'd1;
    cycle();
    checks++;
    if (Rd_a !== 32'd1 || Wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got rd=%h rdy=%b expected 00000001/1", Rd_a, Wr_ready);
    end
    Wr_index = 32'd5; Wr_data = 32'd2;
    cycle();
    checks++;
    if (Rd_a !== 32'd2 || Commit_count !== 32'd1) begin
      errors++;
      $display("FAIL b2b_second: got rd=%h cnt=%0d expected 00000002/1", Rd_a, Commit_count);
    end
    Wr_index = 32'd6; Wr_data = 32'd3;
    cycle();
    idle();
    #1;
    checks++;
    if (Rd_a !== 32'd2 || Rd_b !== 32'd3 || Commit_count !== 32'd2) begin
      errors++;
      $display("FAIL b2b_third: got %h/%h cnt=%0d expected 00000002/00000003/2", Rd_a, Rd_b, Commit_count);
    end
    cycle();
    checks++;
    if (Rd_a !== 32'd2 || Rd_b !== 32'd3 || Commit_count !== 32'd3) begin
      errors++;
      $display("FAIL b2b_final: got %h/%h cnt=%0d expected 00000002/00000003/3", Rd_a, Rd_b, Commit_count);
    end
    // staged value must override the older array content for index 5
    Wr_valid = 1'b1; Wr_index = 32'd5; Wr_data = 32'h77;
    Rd_b_index = 32'd5;
    cycle();
    Wr_valid = 1'b0; Stall = 1'b1;
    #1;
    checks++;
    if (Rd_a !== 32'h77 || Rd_b !== 32'h77) begin
      errors++;
      $display("FAIL b2b_bypass_priority: got %h/%h expected 00000077/00000077", Rd_a, Rd_b);
    end
    idle();
    cycle();
  endtask

  task automatic test_stall();
    do_reset();
    Wr_valid = 1'b1; Wr_index = 32'd7; Wr_data = 32'hAA;
    cycle();
    Wr_index = 32'd8; Wr_data = 32'hBB; Stall = 1'b1;
    Rd_a_index = 32'd7; Rd_b_index = 32'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (Wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b expected 0", i, Wr_ready);
      end
      checks++;
      if (Rd_a !== 32'hAA || Rd_b !== 32'd0) begin
        errors++;
        $display("FAIL stall_reads[%0d]: got %h/%h expected 000000aa/00000000", i, Rd_a, Rd_b);
      end
      checks++;
      if (Commit_count !== 32'd0 || Discard_count !== 32'd0) begin
        errors++;
        $display("FAIL stall_counts[%0d]: got %0d/%0d expected 0/0", i, Commit_count, Discard_count);
      end
      cycle();
    end
    idle();
    #1;
    checks++;
    if (Wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b expected 1", Wr_ready);
    end
    cycle();
    checks++;
    if (Commit_count !== 32'd1 || Rd_a !== 32'hAA || Rd_b !== 32'd0) begin
      errors++;
      $display("FAIL stall_release: got cnt=%0d %h/%h expected 1/000000aa/00000000", Commit_count, Rd_a, Rd_b);
    end
    // stall with an empty stage still accepts a write
    Stall = 1'b1;
    #1;
    checks++;
    if (Wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_empty_ready: got %b expected 1", Wr_ready);
    end
    Wr_valid = 1'b1; Wr_index = 32'd9; Wr_data = 32'h99; Rd_a_index = 32'd9;
    cycle();
    Wr_valid = 1'b0;
    #1;
    checks++;
    if (Wr_ready !== 1'b0 || Rd_a !== 32'h99 || Commit_count !== 32'd1) begin
      errors++;
      $display("FAIL stall_empty_staged: got rdy=%b rd=%h cnt=%0d expected 0/00000099/1", Wr_ready, Rd_a, Commit_count);
    end
    Stall = 1'b0;
    cycle();
    checks++;
    if (Commit_count !== 32'd2 || Rd_a !== 32'h99 || Wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_empty_commit: got cnt=%0d rd=%h rdy=%b expected 2/00000099/1", Commit_count, Rd_a, Wr_ready);
    end
  endtask

  task automatic test_reset_pending();
    Wr_valid = 1'b1; Wr_index = 32'h11; Wr_data = 32'h1;
    cycle();
    Wr_index = 32'd2; Wr_data = 32'h55;
    cycle();
    idle();
    Rd_a_index = 32'd2; Rd_b_index = 32'd9;
    #1;
    checks++;
    if (Rd_a !== 32'h55 || Discard_count !== 32'd1) begin
      errors++;
      $display("FAIL pend_staged: got rd=%h disc=%0d expected 00000055/1", Rd_a, Discard_count);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (Rd_a !== 32'd0 || Rd_b !== 32'd0) begin
      errors++;
      $display("FAIL pend_reads: got %h/%h expected 00000000/00000000", Rd_a, Rd_b);
    end
    checks++;
    if (Commit_count !== 32'd0 || Discard_count !== 32'd0) begin
      errors++;
      $display("FAIL pend_counts: got %0d/%0d expected 0/0", Commit_count, Discard_count);
    end
    Stall = 1'b1;
    #1;
    checks++;
    if (Wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL pend_stage_empty: got rdy=%b expected 1", Wr_ready);
    end
    Stall = 1'b0;
    cycle();
    checks++;
    if (Rd_a !== 32'd0 || Commit_count !== 32'd0) begin
      errors++;
      $display("FAIL pend_lost: got rd=%h cnt=%0d expected 00000000/0", Rd_a, Commit_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_discard();
    test_back_to_back();
    test_stall();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_sink.md
# reg_sink

Destination-side register sink for the 32-bit datapath: it receives a 32-bit destination index and result word, decodes the index into one of 16 architectural registers, and commits the write through a one-entry staging register with read bypass. Index 16 (the null destination that the upstream destination muxer substitutes when a write is disabled) and any higher index are consumed and dropped without a register update, and are counted. It sits at the end of the execute path and serves the two operand read ports of the decode stage.

## Interface
- UUID, 0, instance identifier XORed into sub-instance UUIDs
- NAME, "", instance label
- NUM_REGS, 16, number of architectural registers; indices 0..NUM_REGS-1 are writable
- NULL_INDEX, 16, null destination index; must equal the constant used by the destination muxer
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- Wr_valid  in  1  write request present
- Wr_ready  out  1  staging register can accept a write this cycle
- Wr_index  in  32  destination index
- Wr_data  in  32  result word
- Stall  in  1  holds the staging register (no commit)
- Rd_a_index, Rd_b_index  in  32  read addresses
- Rd_a, Rd_b  out  32  read data (combinational)
- Commit_count  out  32  registered count of committed register writes
- Discard_count  out  32  registered count of accepted null/out-of-range writes

## Operation
- Accept: Wr_valid && Wr_ready at a rising edge. Wr_ready = !(stage_valid && Stall).
- On accept, Wr_index >= NUM_REGS (including NULL_INDEX): not staged; Discard_count += 1 at that edge; stage_valid is left unchanged by the request.
- On accept with Wr_index < NUM_REGS: stage_index <= Wr_index[3:0], stage_data <= Wr_data, stage_valid <= 1.
- Commit: at any edge with stage_valid && !Stall: regs[stage_index] <= stage_data, Commit_count += 1; stage_valid clears unless a new valid write is accepted at the same edge (back-to-back, one write per cycle sustained).
- Stall with stage_valid: array, stage and Commit_count hold; Wr_ready low, so no write is accepted. Stall with stage empty: a write is still accepted (Wr_ready high).
- Reads: index >= NUM_REGS returns 0. Otherwise, if stage_valid and stage_index == read index, the staged data is returned (bypass); else regs[index]. Both ports are independent; both may read the same address.
- Counters wrap modulo 2^32.
- Reset: all 16 registers 0, stage_valid 0, Commit_count 0, Discard_count 0. Reset has priority over accept and commit at the same edge. A staged write pending at reset is lost.

## Timing
- Write presented in cycle N: staged at edge N, visible on the read ports in cycle N+1 through the bypass, in the array after edge N+1 (if unstalled).
- Read latency 0 (combinational from the array and stage). No combinational path from Wr_* to Rd_*.
- Wr_ready depends only on registered state and Stall.
- Discard_count updates at the accept edge; Commit_count updates at the commit edge.

## Structure
- Shared package: NUM_REGS = 16, NULL_INDEX = 32'h10 (single definition, also used by the destination muxer), REG_W = 32.
- One natural sub-module: reg_sink_stage (staging register, stage_valid/Wr_ready logic, commit strobe); the array, bypass and counters live in reg_sink.

## Test plan
- Reset, then read indices 0..15 and 16 on both ports -> all 0; Wr_ready = 1; both counters 0.
- Write idx 3 = 0xDEADBEEF at cycle N, read 3 in N+1 -> 0xDEADBEEF via bypass; read 3 in N+3 -> same from array; Commit_count = 1.
- Write idx 16 = 0x12345678, then idx 0x40 = 1 -> no register changes; Discard_count = 2; Commit_count = 0.
- Back-to-back writes idx 5 = 1, 5 = 2, 6 = 3 on consecutive cycles -> read 5 = 2 and read 6 = 3; Commit_count = 3.
- Stage idx 7 = 0xAA, hold Stall for 3 cycles -> Wr_ready = 0, read 7 = 0xAA via bypass, regs[7] still 0; Stall released -> commit, Commit_count = 1.
- Stage idx 2 = 0x55, assert rst at the next edge -> read 2 = 0, both counters 0, stage_valid = 0.
